// File: rtl/projectile_engine_if.sv
// Launch channel of the projectile engine: valid/ready handshake plus the
// launch position and direction bits.
interface projectile_engine_if #(
    parameter int unsigned CW = 10
);
    logic          fire_valid;
    logic          fire_ready;
    logic [CW-1:0] fire_x;
    logic [CW-1:0] fire_y;
    logic          fire_dx;
    logic          fire_dy;

    modport master (
        output fire_valid, fire_x, fire_y, fire_dx, fire_dy,
        input  fire_ready
    );

    modport slave (
        input  fire_valid, fire_x, fire_y, fire_dx, fire_dy,
        output fire_ready
    );
endinterface

// File: rtl/projectile_engine.sv
// Projectile engine: NUM_PROJ slots that are launched through the fire
// channel, moved and bounced inside the arena once per tick (one slot per
// cycle), cleared on target collision, and queried per pixel for drawing.
// Optional feature: define PROJ_LIFETIME_EN to give each slot a 3-bit bounce
// counter that retires the projectile after its eighth clamp event.
module projectile_engine #(
    parameter int unsigned NUM_PROJ = 4,
    parameter int unsigned CW       = 10,
    parameter int unsigned XMIN     = 364,
    parameter int unsigned XMAX     = 563,
    parameter int unsigned YMIN     = 221,
    parameter int unsigned YMAX     = 320,
    parameter int unsigned PSIZE    = 8,
    parameter int unsigned TSIZE    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    projectile_engine_if.slave  fire,
    input  logic [3:0]          speed,
    input  logic [CW-1:0]       tgt_x,
    input  logic [CW-1:0]       tgt_y,
    input  logic [CW-1:0]       hcount,
    input  logic [CW-1:0]       vcount,
    output logic                pix_hit,
    output logic [3:0]          pix_idx,
    output logic                tgt_hit,
    output logic [NUM_PROJ-1:0] active,
    output logic                busy
);

    localparam int unsigned IW = 4;
    localparam int unsigned EW = CW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_PROJ-1:0]   act_q, act_d;
    logic [CW-1:0]         px_q [NUM_PROJ];
    logic [CW-1:0]         px_d [NUM_PROJ];
    logic [CW-1:0]         py_q [NUM_PROJ];
    logic [CW-1:0]         py_d [NUM_PROJ];
    logic                  dx_q [NUM_PROJ];
    logic                  dx_d [NUM_PROJ];
    logic                  dy_q [NUM_PROJ];
    logic                  dy_d [NUM_PROJ];
`ifdef PROJ_LIFETIME_EN
    logic [2:0]            life_q [NUM_PROJ];
    logic [2:0]            life_d [NUM_PROJ];
    logic                  clamp;
`endif
    logic                  tgt_hit_q, tgt_hit_d;
    logic                  pix_hit_q, pix_hit_d;
    logic [IW-1:0]         pix_idx_q, pix_idx_d;
    logic                  busy_q, busy_d;

    logic                  free_found;
    logic [IW-1:0]         free_idx;
    logic                  fire_ready_c;
    logic [EW-1:0]         rx, ry;
    logic                  lox, hix, loy, hiy;
    logic [CW-1:0]         nx, ny;
    logic                  ndx, ndy;
    logic                  expire;

    // Moved coordinate at CW+1 bits so a borrow or carry shows in the top bit.
    function automatic logic [EW-1:0] step_res(input logic [CW-1:0] pos,
                                               input logic dir,
                                               input logic [3:0] spd);
        if (dir) step_res = {1'b0, pos} - EW'(spd);
        else     step_res = {1'b0, pos} + EW'(spd);
    endfunction

    // At or below the minimum, or borrowed below zero while decreasing.
    function automatic logic at_lo(input logic [EW-1:0] res, input logic dir,
                                   input logic [CW-1:0] amin);
        at_lo = (dir && res[CW]) || (!res[CW] && (res[CW-1:0] <= amin));
    endfunction

    // At or above the maximum, or carried out while increasing.
    function automatic logic at_hi(input logic [EW-1:0] res, input logic dir,
                                   input logic [CW-1:0] amax);
        at_hi = (!dir && res[CW]) || (!res[CW] && (res[CW-1:0] >= amax));
    endfunction

    // Half-open overlap of the projectile square and the target square.
    function automatic logic overlap(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                     input logic [CW-1:0] bx, input logic [CW-1:0] by);
        overlap = ({1'b0, ax} < ({1'b0, bx} + EW'(TSIZE))) &&
                  ({1'b0, bx} < ({1'b0, ax} + EW'(PSIZE))) &&
                  ({1'b0, ay} < ({1'b0, by} + EW'(TSIZE))) &&
                  ({1'b0, by} < ({1'b0, ay} + EW'(PSIZE)));
    endfunction

    // Query pixel inside the projectile square.
    function automatic logic covers(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                    input logic [CW-1:0] h, input logic [CW-1:0] v);
        covers = ({1'b0, h} >= {1'b0, ax}) && ({1'b0, h} < ({1'b0, ax} + EW'(PSIZE))) &&
                 ({1'b0, v} >= {1'b0, ay}) && ({1'b0, v} < ({1'b0, ay} + EW'(PSIZE)));
    endfunction

    // Next-state: launch, sweep update, collision, pixel query.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        act_d     = act_q;
        px_d      = px_q;
        py_d      = py_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
`ifdef PROJ_LIFETIME_EN
        life_d    = life_q;
        clamp     = 1'b0;
`endif
        tgt_hit_d = 1'b0;
        pix_hit_d = 1'b0;
        pix_idx_d = '0;
        rx        = '0;
        ry        = '0;
        lox       = 1'b0;
        hix       = 1'b0;
        loy       = 1'b0;
        hiy       = 1'b0;
        nx        = '0;
        ny        = '0;
        ndx       = 1'b0;
        ndy       = 1'b0;
        expire    = 1'b0;

        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(NUM_PROJ); i++) begin
            if (!act_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        fire_ready_c = (state_q == IDLE) && !tick && free_found;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end else if (fire.fire_valid && fire_ready_c) begin
                    for (int i = 0; i < int'(NUM_PROJ); i++) begin
                        if (IW'(i) == free_idx) begin
                            act_d[i] = 1'b1;
                            px_d[i]  = fire.fire_x;
                            py_d[i]  = fire.fire_y;
                            dx_d[i]  = fire.fire_dx;
                            dy_d[i]  = fire.fire_dy;
`ifdef PROJ_LIFETIME_EN
                            life_d[i] = 3'd7;
`endif
                        end
                    end
                end
            end
            SWEEP: begin
                for (int i = 0; i < int'(NUM_PROJ); i++) begin
                    if ((IW'(i) == idx_q) && act_q[i]) begin
                        rx  = step_res(px_q[i], dx_q[i], speed);
                        ry  = step_res(py_q[i], dy_q[i], speed);
                        lox = at_lo(rx, dx_q[i], CW'(XMIN));
                        hix = at_hi(rx, dx_q[i], CW'(XMAX));
                        loy = at_lo(ry, dy_q[i], CW'(YMIN));
                        hiy = at_hi(ry, dy_q[i], CW'(YMAX));

                        if (lox)      begin nx = CW'(XMIN);  ndx = 1'b0;     end
                        else if (hix) begin nx = CW'(XMAX);  ndx = 1'b1;     end
                        else          begin nx = rx[CW-1:0]; ndx = dx_q[i];  end
                        if (loy)      begin ny = CW'(YMIN);  ndy = 1'b0;     end
                        else if (hiy) begin ny = CW'(YMAX);  ndy = 1'b1;     end
                        else          begin ny = ry[CW-1:0]; ndy = dy_q[i];  end

`ifdef PROJ_LIFETIME_EN
                        // A slot clamping on both axes still loses one life only.
                        clamp = lox || hix || loy || hiy;
                        if (clamp) begin
                            if (life_q[i] == 3'd0) expire = 1'b1;
                            else                   life_d[i] = life_q[i] - 3'd1;
                        end
`endif

                        if (expire || overlap(nx, ny, tgt_x, tgt_y)) begin
                            act_d[i]  = 1'b0;
                            px_d[i]   = '0;
                            py_d[i]   = '0;
                            dx_d[i]   = 1'b0;
                            dy_d[i]   = 1'b0;
`ifdef PROJ_LIFETIME_EN
                            life_d[i] = 3'd0;
`endif
                            tgt_hit_d = !expire;
                        end else begin
                            px_d[i] = nx;
                            py_d[i] = ny;
                            dx_d[i] = ndx;
                            dy_d[i] = ndy;
                        end
                    end
                end
                if (idx_q == IW'(NUM_PROJ - 1)) state_d = IDLE;
                else                            idx_d   = idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Highest index first so the lowest covering slot wins.
        for (int i = int'(NUM_PROJ) - 1; i >= 0; i--) begin
            if (act_q[i] && covers(px_q[i], py_q[i], hcount, vcount)) begin
                pix_hit_d = 1'b1;
                pix_idx_d = IW'(i);
            end
        end

        busy_d = (state_d == SWEEP);
    end

    // State and slot registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            act_q     <= '0;
            tgt_hit_q <= 1'b0;
            pix_hit_q <= 1'b0;
            pix_idx_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < int'(NUM_PROJ); i++) begin
                px_q[i]   <= '0;
                py_q[i]   <= '0;
                dx_q[i]   <= 1'b0;
                dy_q[i]   <= 1'b0;
`ifdef PROJ_LIFETIME_EN
                life_q[i] <= 3'd0;
`endif
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            act_q     <= act_d;
            tgt_hit_q <= tgt_hit_d;
            pix_hit_q <= pix_hit_d;
            pix_idx_q <= pix_idx_d;
            busy_q    <= busy_d;
            for (int i = 0; i < int'(NUM_PROJ); i++) begin
                px_q[i]   <= px_d[i];
                py_q[i]   <= py_d[i];
                dx_q[i]   <= dx_d[i];
                dy_q[i]   <= dy_d[i];
`ifdef PROJ_LIFETIME_EN
                life_q[i] <= life_d[i];
`endif
            end
        end
    end

    assign fire.fire_ready = fire_ready_c;
    assign pix_hit         = pix_hit_q;
    assign pix_idx         = pix_idx_q;
    assign tgt_hit         = tgt_hit_q;
    assign active          = act_q;
    assign busy            = busy_q;

endmodule

// File: doc/projectile_engine.md
PROJECTILE_ENGINE -- requirements
Module: projectile_engine

Interface
REQ-001 Parameter NUM_PROJ, default 4, number of projectile slots (1..16).
REQ-002 Parameter CW, default 10, coordinate width in bits.
REQ-003 Parameter XMIN/XMAX/YMIN/YMAX, default 364/563/221/320, arena bounce limits, inclusive.
REQ-004 Parameter PSIZE, default 8, projectile square side in pixels.
REQ-005 Parameter TSIZE, default 16, target square side in pixels.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 tick  in  1  single-cycle movement strobe.
REQ-009 fire_valid  in  1  launch request.
REQ-010 fire_ready  out  1  launch can be accepted this cycle.
REQ-011 fire_x, fire_y  in  CW each  launch position.
REQ-012 fire_dx, fire_dy  in  1 each  direction: 0 means increasing, 1 means decreasing.
REQ-013 speed  in  4  step per tick, unsigned.
REQ-014 tgt_x, tgt_y  in  CW each  target top-left corner.
REQ-015 hcount, vcount  in  CW each  pixel query coordinates.
REQ-016 pix_hit  out  1  query pixel lies inside an active projectile.
REQ-017 pix_idx  out  4  lowest-index slot covering the query pixel.
REQ-018 tgt_hit  out  1  one-cycle pulse on a target collision.
REQ-019 active  out  NUM_PROJ  slot occupancy mask.
REQ-020 busy  out  1  update sweep in progress.

Function
REQ-021 FSM states are IDLE and SWEEP; IDLE goes to SWEEP on tick; SWEEP returns to IDLE after slot NUM_PROJ-1 is processed.
REQ-022 SWEEP processes one slot per cycle, index 0 upward, so busy is high for exactly NUM_PROJ cycles.
REQ-023 fire_ready is 1 only in IDLE with tick low and at least one slot inactive.
REQ-024 A launch is accepted when fire_valid and fire_ready are both high.
REQ-025 On acceptance, the lowest-index inactive slot loads fire_x/fire_y/fire_dx/fire_dy and becomes active on the next cycle.
REQ-026 tick arriving in the same cycle as fire_valid has priority; the launch is held off until fire_ready returns.
REQ-027 tick arriving during SWEEP is ignored, with no queueing.
REQ-028 Active slot move: each axis adds or subtracts speed according to its direction bit, computed at CW+1 bits.
REQ-029 Bounce: if the result is <= the axis minimum or borrows below zero, clamp to the minimum and set direction to 0.
REQ-030 Bounce: if the result is >= the axis maximum or overflows, clamp to the maximum and set direction to 1.
REQ-031 Inactive slots are untouched during the sweep.
REQ-032 Collision: after the move, if the PSIZE and TSIZE squares overlap (half-open intervals), the slot is cleared and tgt_hit pulses 1 cycle.
REQ-033 More than one hit in one sweep yields one tgt_hit pulse per hitting slot, on the cycle after that slot's processing.
REQ-034 Pixel query: pix_hit and pix_idx are registered, 1-cycle latency after hcount/vcount.
REQ-035 Pixel query covers x <= hcount < x+PSIZE, same for y, active slots only.
REQ-036 pix_idx is 0 when pix_hit is 0.
REQ-037 speed 0 means positions do not change, but collision checks still run.

Reset
REQ-038 rst clears all slots: active=0, positions 0, directions 0.
REQ-039 rst sets FSM to IDLE.
REQ-040 rst sets tgt_hit=0, pix_hit=0, pix_idx=0, busy=0.
REQ-041 fire_ready follows REQ-023 after reset release, so it is 1.
REQ-042 rst asserted mid-sweep aborts the sweep immediately; no partial updates survive.

Configuration
REQ-043 Macro PROJ_LIFETIME_EN defined: each slot carries a 3-bit bounce counter, loaded with 7 at launch.
REQ-044 With PROJ_LIFETIME_EN, the counter decrements on every clamp event; a slot clamping on both axes in one tick decrements once.
REQ-045 With PROJ_LIFETIME_EN, a slot whose counter is 0 at a clamp becomes inactive with no tgt_hit.
REQ-046 PROJ_LIFETIME_EN undefined: no counter exists, and projectiles live until a target collision or reset.

Verification
REQ-047 Reset then fire_valid with (400,250,0,0), speed 4: fire_ready=1, slot0 active; one tick gives slot0 (404,254), busy high 4 cycles.
REQ-048 Fire 4 launches with NUM_PROJ=4: fire_ready=0 after the fourth; a fifth fire_valid is ignored, active=4'b1111.
REQ-049 Slot at x=561, dx=0, speed 4 with tick: x=563, dx=1; the next tick gives x=559.
REQ-050 Target at (420,260), projectile launched at (410,255), speed 4 dx=0 dy=0, one tick: tgt_hit pulses once, slot cleared.
REQ-051 Slot0 at (400,250), query hcount=403, vcount=257: the next cycle gives pix_hit=1, pix_idx=0; hcount=408 gives pix_hit=0.
REQ-052 PROJ_LIFETIME_EN, projectile bouncing repeatedly: the slot deactivates on its eighth clamp event, tgt_hit stays 0; rst mid-sweep gives active=0 and busy=0 immediately.
